// File: rtl/lsu_ctrl_if.sv
// -----------------------------------------------------------------------------
// lsu_ctrl_if
//   Word-wide valid/ready data-bus between the load/store unit and memory.
//   Signals:
//     mem_valid   request present (driven by the LSU)
//     mem_ready   memory accepts the request
//     mem_we      1 = write, 0 = read
//     mem_addr    word-aligned byte address
//     mem_wdata   lane-replicated write data
//     mem_wmask   byte enables, 4'b0000 on reads
//     mem_rvalid  read data valid
//     mem_rdata   read word
//   Modports:
//     master  the LSU side
//     slave   the memory side
// -----------------------------------------------------------------------------
interface lsu_ctrl_if;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_wmask,
        input  mem_ready,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_valid,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wmask,
        output mem_ready,
        output mem_rvalid,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
//   Multi-cycle load/store unit sitting after the rv32e execute stage. Takes one
//   memory op at a time, runs it on the valid/ready bus in lsu_ctrl_if, builds
//   byte masks / replicated store data and sign/zero-extends load data.
//   busy_o stays high from accept until the response pulse so fetch and the
//   register file stall.
//
// Parameters:
//   TIMEOUT   bus wait limit in cycles (REQ and WAIT_R); 0 = wait forever
//
// Optional build macro:
//   LSU_MISALIGN_TRAP_EN  misaligned lh/lhu/sh/lw/sw are rejected without a bus
//                         cycle (resp_err_o=1) and the extra output misalign_o
//                         pulses with resp_valid_o. Without it the low address
//                         bits are simply ignored for lane selection.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid_i         op present
//   req_ready_o         LSU idle and able to accept
//   req_we_i            1 = store, 0 = load
//   req_func3_i         RV func3
//   req_addr_i          byte address (rs1 + imm)
//   req_wdata_i         rs2 value
//   resp_valid_o        one-cycle completion pulse
//   resp_rdata_o        extended load data, 0 for stores and errors
//   resp_err_o          illegal func3, timeout or misalign (with resp_valid_o)
//   busy_o              op in flight
//   misalign_o          (LSU_MISALIGN_TRAP_EN only) misaligned op rejected
//   mem                 memory bus, master side
// -----------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_func3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic        busy_o,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        misalign_o,
`endif
    lsu_ctrl_if.master  mem
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_WAIT_R = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      state_q;
    logic [31:0] addr_q;
    logic [2:0]  func3_q;
    logic        we_q;
    logic [31:0] to_cnt_q;
    logic        req_ready_q;
    logic        busy_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;
    logic        mem_valid_q;
    logic        mem_we_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_wmask_q;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_q;
    logic        mis_s;
`endif

    logic        legal_s;
    logic        reject_s;
    logic [3:0]  mask_s;
    logic [31:0] wdata_s;
    logic [31:0] ext_s;
    logic        timeout_hit_s;

    // Stores allow sb/sh/sw only; loads allow lb/lh/lw/lbu/lhu.
    function automatic logic func3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        if (we) begin
            case (f3)
                3'b000, 3'b001, 3'b010: ok = 1'b1;
                default:                ok = 1'b0;
            endcase
        end else begin
            case (f3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ok = 1'b1;
                default:                                ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] a);
        logic [3:0] m;
        case (f3)
            3'b000:  m = 4'b0001 << a;
            3'b001:  m = a[1] ? 4'b1100 : 4'b0011;
            3'b010:  m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    // Replicate the narrow datum across every lane so the mask alone picks it.
    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3)
            3'b000:  d = {4{wd[7:0]}};
            3'b001:  d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            2'b11:   b = rd[31:24];
            default: b = 8'h00;
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = rd;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic m;
        case (f3)
            3'b001, 3'b101: m = a[0];
            3'b010:         m = (a != 2'b00);
            default:        m = 1'b0;
        endcase
        return m;
    endfunction
`endif

    // Accept-time decode of the incoming op plus load extension of the bus word.
    always_comb begin
        legal_s       = func3_legal(req_we_i, req_func3_i);
        mask_s        = req_we_i ? store_mask(req_func3_i, req_addr_i[1:0]) : 4'b0000;
        wdata_s       = store_data(req_func3_i, req_wdata_i);
        ext_s         = load_extend(func3_q, addr_q[1:0], mem.mem_rdata);
        // Counter holds cycles already spent waiting; hit on the TIMEOUT-th one.
        timeout_hit_s = (TIMEOUT != 32'd0) && ((to_cnt_q + 32'd1) == TIMEOUT);
`ifdef LSU_MISALIGN_TRAP_EN
        mis_s         = misaligned(req_func3_i, req_addr_i[1:0]);
        reject_s      = !legal_s || mis_s;
`else
        reject_s      = !legal_s;
`endif
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'd0;
            func3_q      <= 3'd0;
            we_q         <= 1'b0;
            to_cnt_q     <= 32'd0;
            req_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wdata_q  <= 32'd0;
            mem_wmask_q  <= 4'd0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid_i) begin
                        addr_q       <= req_addr_i;
                        func3_q      <= req_func3_i;
                        we_q         <= req_we_i;
                        to_cnt_q     <= 32'd0;
                        req_ready_q  <= 1'b0;
                        busy_q       <= 1'b1;
                        resp_rdata_q <= 32'd0;
                        if (reject_s) begin
                            // Rejected ops complete without touching the bus.
                            state_q      <= S_DONE;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                            misalign_q   <= mis_s && legal_s;
`endif
                        end else begin
                            state_q     <= S_REQ;
                            mem_valid_q <= 1'b1;
                            mem_we_q    <= req_we_i;
                            mem_wmask_q <= mask_s;
                            mem_wdata_q <= wdata_s;
                        end
                    end
                end
                S_REQ: begin
                    if (mem.mem_ready) begin
                        mem_valid_q <= 1'b0;
                        to_cnt_q    <= 32'd0;
                        if (we_q) begin
                            state_q      <= S_DONE;
                            resp_valid_q <= 1'b1;
                        end else if (mem.mem_rvalid) begin
                            state_q      <= S_DONE;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= ext_s;
                        end else begin
                            state_q <= S_WAIT_R;
                        end
                    end else if (timeout_hit_s) begin
                        state_q      <= S_DONE;
                        mem_valid_q  <= 1'b0;
                        to_cnt_q     <= 32'd0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + 32'd1;
                    end
                end
                S_WAIT_R: begin
                    if (mem.mem_rvalid) begin
                        state_q      <= S_DONE;
                        to_cnt_q     <= 32'd0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= ext_s;
                    end else if (timeout_hit_s) begin
                        state_q      <= S_DONE;
                        to_cnt_q     <= 32'd0;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                    end else begin
                        to_cnt_q <= to_cnt_q + 32'd1;
                    end
                end
                S_DONE: begin
                    // Response lasts one cycle; req_valid is not looked at here.
                    state_q      <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    busy_q       <= 1'b0;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'd0;
`ifdef LSU_MISALIGN_TRAP_EN
                    misalign_q   <= 1'b0;
`endif
                end
                default: begin
                    state_q      <= S_IDLE;
                    req_ready_q  <= 1'b1;
                    busy_q       <= 1'b0;
                    resp_valid_q <= 1'b0;
                    mem_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o   = req_ready_q;
    assign busy_o        = busy_q;
    assign resp_valid_o  = resp_valid_q;
    assign resp_err_o    = resp_err_q;
    assign resp_rdata_o  = resp_rdata_q;
    assign mem.mem_valid = mem_valid_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = {addr_q[31:2], 2'b00};
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_wmask = mem_wmask_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_o    = misalign_q;
`endif

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl
//   Directed bench for lsu_ctrl (TIMEOUT=4). A table of single-transaction
//   vectors with minimum-latency bus behaviour, followed by hand-written
//   sequences for bus stalls, delayed read data, timeout and reset mid-op.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    lsu_ctrl_if mem_if();

    lsu_ctrl #(.TIMEOUT(32'd4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_func3_i  (req_func3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .busy_o       (busy),
`ifdef LSU_MISALIGN_TRAP_EN
        .misalign_o   (misalign),
`endif
        .mem          (mem_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;     // word returned by memory (loads)
        logic        bus;       // a bus cycle is expected
        logic [3:0]  exp_mask;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_mis;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic bus, input logic [3:0] mask,
                                input logic [31:0] ewdata, input logic [31:0] erdata,
                                input logic err, input logic mis);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.bus = bus; v.exp_mask = mask; v.exp_wdata = ewdata; v.exp_rdata = erdata;
        v.exp_err = err; v.exp_mis = mis;
        return v;
    endfunction

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_func3 = f3;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
    endtask

    vec_t vq[$];
    vec_t v;

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_func3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        mem_if.mem_ready = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'd0;

        //                we    f3      addr          wdata         rdata         bus   mask     exp_wdata     exp_rdata     err   mis
        vq.push_back(mk(1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0,        1'b1, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1'b0, 1'b0));
        vq.push_back(mk(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0,        1'b1, 4'b1000, 32'hA5A5_A5A5, 32'h0,        1'b0, 1'b0));
        vq.push_back(mk(1'b1, 3'b000, 32'h0000_0100, 32'h1234_5678, 32'h0,        1'b1, 4'b0001, 32'h7878_7878, 32'h0,        1'b0, 1'b0));
        vq.push_back(mk(1'b1, 3'b001, 32'h0000_0102, 32'h0000_BEEF, 32'h0,        1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0,        1'b0, 1'b0));
        vq.push_back(mk(1'b1, 3'b001, 32'h0000_0100, 32'hCAFE_1234, 32'h0,        1'b1, 4'b0011, 32'h1234_1234, 32'h0,        1'b0, 1'b0));
        vq.push_back(mk(1'b0, 3'b000, 32'h0000_0102, 32'h0,        32'h1280_FF00, 1'b1, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 3'b100, 32'h0000_0102, 32'h0,        32'h1280_FF00, 1'b1, 4'b0000, 32'h0,        32'h0000_0080, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h1280_FF00, 1'b1, 4'b0000, 32'h0,        32'hFFFF_FFFF, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h1280_FF00, 1'b1, 4'b0000, 32'h0,        32'h0000_0012, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8001_1234, 1'b1, 4'b0000, 32'h0,        32'hFFFF_8001, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h8001_1234, 1'b1, 4'b0000, 32'h0,        32'h0000_8001, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 3'b001, 32'h0000_0100, 32'h0,        32'h8001_9234, 1'b1, 4'b0000, 32'h0,        32'hFFFF_9234, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 3'b010, 32'h0000_0108, 32'h0,        32'h89AB_CDEF, 1'b1, 4'b0000, 32'h0,        32'h89AB_CDEF, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h89AB_CDEF, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0));
        vq.push_back(mk(1'b0, 3'b110, 32'h0000_0100, 32'h0,        32'h89AB_CDEF, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0));
        vq.push_back(mk(1'b0, 3'b111, 32'h0000_0100, 32'h0,        32'h89AB_CDEF, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0));
        vq.push_back(mk(1'b1, 3'b011, 32'h0000_0100, 32'h1111_1111, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0));
        vq.push_back(mk(1'b1, 3'b100, 32'h0000_0100, 32'h1111_1111, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b0));
`ifdef LSU_MISALIGN_TRAP_EN
        vq.push_back(mk(1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h89AB_CDEF, 1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b1));
        vq.push_back(mk(1'b1, 3'b001, 32'h0000_0103, 32'h0000_5A5A, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b1, 1'b1));
`else
        vq.push_back(mk(1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h89AB_CDEF, 1'b1, 4'b0000, 32'h0,        32'h89AB_CDEF, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 3'b001, 32'h0000_0103, 32'h0000_5A5A, 32'h0,        1'b1, 4'b1100, 32'h5A5A_5A5A, 32'h0,        1'b0, 1'b0));
`endif

        // Reset state
        tick();
        tick();
        chk("rst.req_ready",  req_ready, 32'd1);
        chk("rst.busy",       busy, 32'd0);
        chk("rst.resp_valid", resp_valid, 32'd0);
        chk("rst.resp_err",   resp_err, 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.mem_valid",  mem_if.mem_valid, 32'd0);
        chk("rst.mem_wmask",  mem_if.mem_wmask, 32'd0);
        chk("rst.mem_addr",   mem_if.mem_addr, 32'd0);
        reset = 1'b0;
        tick();

        // Table vectors: memory accepts at once, read data returned with ready
        foreach (vq[i]) begin
            v = vq[i];
            issue(v.we, v.f3, v.addr, v.wdata);
            if (v.bus) begin
                chk($sformatf("v%0d.mem_valid", i), mem_if.mem_valid, 32'd1);
                chk($sformatf("v%0d.mem_addr", i),  mem_if.mem_addr, v.addr & 32'hFFFF_FFFC);
                chk($sformatf("v%0d.mem_we", i),    mem_if.mem_we, v.we);
                chk($sformatf("v%0d.mem_wmask", i), mem_if.mem_wmask, v.exp_mask);
                if (v.we) begin
                    chk($sformatf("v%0d.mem_wdata", i), mem_if.mem_wdata, v.exp_wdata);
                end
                chk($sformatf("v%0d.busy", i),       busy, 32'd1);
                chk($sformatf("v%0d.resp_early", i), resp_valid, 32'd0);
                mem_if.mem_ready  = 1'b1;
                mem_if.mem_rvalid = !v.we;
                mem_if.mem_rdata  = v.rdata;
                tick();
                mem_if.mem_ready  = 1'b0;
                mem_if.mem_rvalid = 1'b0;
                mem_if.mem_rdata  = 32'd0;
            end
            chk($sformatf("v%0d.resp_valid", i), resp_valid, 32'd1);
            chk($sformatf("v%0d.resp_err", i),   resp_err, v.exp_err);
            chk($sformatf("v%0d.resp_rdata", i), resp_rdata, v.exp_rdata);
            chk($sformatf("v%0d.mem_idle", i),   mem_if.mem_valid, 32'd0);
            chk($sformatf("v%0d.ready_done", i), req_ready, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
            chk($sformatf("v%0d.misalign", i),   misalign, v.exp_mis);
`endif
            tick();
            chk($sformatf("v%0d.resp_pulse", i), resp_valid, 32'd0);
            chk($sformatf("v%0d.ready_back", i), req_ready, 32'd1);
        end

        // Bus stall then read data 3 cycles after the accepting mem_ready
        issue(1'b0, 3'b000, 32'h0000_0102, 32'd0);
        for (int c = 0; c < 2; c++) begin
            chk("stall.mem_valid", mem_if.mem_valid, 32'd1);
            chk("stall.mem_addr",  mem_if.mem_addr, 32'h0000_0100);
            tick();
        end
        chk("stall.mem_valid2", mem_if.mem_valid, 32'd1);
        mem_if.mem_ready = 1'b1;
        tick();
        mem_if.mem_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            chk("waitr.mem_valid",  mem_if.mem_valid, 32'd0);
            chk("waitr.busy",       busy, 32'd1);
            chk("waitr.resp_valid", resp_valid, 32'd0);
            tick();
        end
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = 32'h1280_FF00;
        tick();
        mem_if.mem_rvalid = 1'b0;
        chk("waitr.resp",  resp_valid, 32'd1);
        chk("waitr.rdata", resp_rdata, 32'hFFFF_FF80);
        chk("waitr.err",   resp_err, 32'd0);
        tick();

        // Timeout: mem_ready never comes, 4 REQ cycles then error response
        issue(1'b0, 3'b010, 32'h0000_0200, 32'd0);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("tmo.mem_valid%0d", c), mem_if.mem_valid, 32'd1);
            chk($sformatf("tmo.resp%0d", c),      resp_valid, 32'd0);
            tick();
        end
        chk("tmo.resp_valid", resp_valid, 32'd1);
        chk("tmo.resp_err",   resp_err, 32'd1);
        chk("tmo.resp_rdata", resp_rdata, 32'd0);
        chk("tmo.mem_valid",  mem_if.mem_valid, 32'd0);
        tick();
        chk("tmo.pulse", resp_valid, 32'd0);

        // Reset while waiting for read data; a late rvalid must be dropped
        issue(1'b0, 3'b010, 32'h0000_0300, 32'd0);
        mem_if.mem_ready = 1'b1;
        tick();
        mem_if.mem_ready = 1'b0;
        chk("rstmid.busy_before", busy, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstmid.busy",       busy, 32'd0);
        chk("rstmid.req_ready",  req_ready, 32'd1);
        chk("rstmid.resp_valid", resp_valid, 32'd0);
        chk("rstmid.mem_valid",  mem_if.mem_valid, 32'd0);
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = 32'h5555_AAAA;
        tick();
        mem_if.mem_rvalid = 1'b0;
        chk("late_rvalid.resp", resp_valid, 32'd0);
        chk("late_rvalid.busy", busy, 32'd0);
        tick();
        chk("late_rvalid.resp2", resp_valid, 32'd0);

        // Normal op after the mid-op reset
        issue(1'b1, 3'b010, 32'h0000_0400, 32'h0BAD_F00D);
        chk("post.mem_wdata", mem_if.mem_wdata, 32'h0BAD_F00D);
        mem_if.mem_ready = 1'b1;
        tick();
        mem_if.mem_ready = 1'b0;
        chk("post.resp_valid", resp_valid, 32'd1);
        chk("post.resp_err",   resp_err, 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
